// File: rtl/mdu_pkg.sv
// Shared op encoding, commit modes, default latencies and op-class helpers for the MDU.
// MADD/MADDU/MSUB/MSUBU only count as multiply ops when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MFHI     = 4'd5,
        MFLO     = 4'd6,
        MTHI     = 4'd7,
        MTLO     = 4'd8,
        MADD     = 4'd9,
        MADDU    = 4'd10,
        MSUB     = 4'd11,
        MSUBU    = 4'd12
    } mdu_op_e;

    // What happens to HI/LO when the in-flight op commits.
    typedef enum logic [1:0] {
        CMT_WRITE = 2'd0,
        CMT_SKIP  = 2'd1,
        CMT_ADD   = 2'd2,
        CMT_SUB   = 2'd3
    } cmt_mode_e;

    localparam int WIDTH_DEF   = 32;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    function automatic logic is_mul(mdu_op_e op);
`ifdef MDU_MADD_EN
        return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
`else
        return op inside {MULT, MULTU};
`endif
    endfunction

    function automatic logic is_muldiv(mdu_op_e op);
        return is_mul(op) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic int max_int(int x, int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Busy-cycle counter: loads the class latency on issue, counts down, flush clears it.
// busy is registered; commit is the strobe for the edge where the last busy cycle ends.
module mdu_lat_counter
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic issue_mul,
    input  logic flush,
    output logic busy,
    output logic commit
);

    localparam int CW = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        commit = 1'b0;
        if (flush) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (issue) begin
            cnt_d  = issue_mul ? MUL_CNT : DIV_CNT;
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                commit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit with HI/LO, flush and done pulse; result computed at issue, committed after MUL_LAT/DIV_LAT busy cycles.
// No backpressure: ops presented while busy are ignored (the stall unit holds them). MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_param
    import mdu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
    cmt_mode_e        temp_mode_q, temp_mode_d;
    logic             done_q, done_d;
    logic             commit;

    logic [2*WIDTH-1:0] prod_s, prod_u, hilo, hilo_new;
    logic [WIDTH-1:0]   a_mag, b_mag, div_n, div_d, uq, ur, quo, rem;
    logic               signed_div;

    assign start = is_muldiv(op) && !busy && !flush;

    mdu_lat_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .issue     (start),
        .issue_mul (is_mul(op)),
        .flush     (flush),
        .busy      (busy),
        .commit    (commit)
    );

    // Signed ops run on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
    always_comb begin
        prod_s     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        signed_div = (op == DIV);
        a_mag      = a[WIDTH-1] ? -a : a;
        b_mag      = b[WIDTH-1] ? -b : b;
        div_n      = signed_div ? a_mag : a;
        div_d      = signed_div ? b_mag : b;
        uq         = (div_d == '0) ? '0 : div_n / div_d;
        ur         = (div_d == '0) ? '0 : div_n % div_d;
        quo        = (signed_div && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
        rem        = (signed_div && a[WIDTH-1]) ? -ur : ur;
    end

    always_comb begin
        temp_hi_d   = temp_hi_q;
        temp_lo_d   = temp_lo_q;
        temp_mode_d = temp_mode_q;
        if (start) begin
            temp_mode_d = CMT_WRITE;
            case (op)
                MULT:  {temp_hi_d, temp_lo_d} = prod_s;
                MULTU: {temp_hi_d, temp_lo_d} = prod_u;
                DIV, DIVU: begin
                    temp_hi_d = rem;
                    temp_lo_d = quo;
                    if (b == '0) temp_mode_d = CMT_SKIP;
                end
`ifdef MDU_MADD_EN
                MADD: begin
                    {temp_hi_d, temp_lo_d} = prod_s;
                    temp_mode_d            = CMT_ADD;
                end
                MADDU: begin
                    {temp_hi_d, temp_lo_d} = prod_u;
                    temp_mode_d            = CMT_ADD;
                end
                MSUB: begin
                    {temp_hi_d, temp_lo_d} = prod_s;
                    temp_mode_d            = CMT_SUB;
                end
                MSUBU: begin
                    {temp_hi_d, temp_lo_d} = prod_u;
                    temp_mode_d            = CMT_SUB;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        hilo     = {hi_q, lo_q};
        hilo_new = hilo;
        case (temp_mode_q)
            CMT_WRITE: hilo_new = {temp_hi_q, temp_lo_q};
            CMT_ADD:   hilo_new = hilo + {temp_hi_q, temp_lo_q};
            CMT_SUB:   hilo_new = hilo - {temp_hi_q, temp_lo_q};
            default:   hilo_new = hilo;
        endcase
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = commit;
        if (commit) begin
            {hi_d, lo_d} = hilo_new;
        end else if (!busy && !flush) begin
            if (op == MTHI) hi_d = a;
            if (op == MTLO) lo_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q        <= '0;
            lo_q        <= '0;
            temp_hi_q   <= '0;
            temp_lo_q   <= '0;
            temp_mode_q <= CMT_WRITE;
            done_q      <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            temp_hi_q   <= temp_hi_d;
            temp_lo_q   <= temp_lo_d;
            temp_mode_q <= temp_mode_d;
            done_q      <= done_d;
        end
    end

    assign done  = done_q;
    assign rdata = (op == MFHI) ? hi_q : (op == MFLO) ? lo_q : '0;

endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage. It is the next generation of the fixed-latency MDU.
- Handles signed/unsigned mult and div, plus mfhi/mflo/mthi/mtlo, on architectural HI/LO registers.
- Width and per-class latency are configurable.
- Adds a flush input that aborts an in-flight operation without disturbing HI/LO, and a result-ready pulse.
- Drives `start` and `busy` to the stall unit exactly as the pipeline expects.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- MUL_LAT, 5: busy cycles for mult/multu; must be at least 1.
- DIV_LAT, 10: busy cycles for div/divu; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears state.
- op  in  4  MDU operation code (package enum); MDU_NONE when the E instruction is not an MDU instruction.
- a  in  WIDTH  rs operand (already forwarded).
- b  in  WIDTH  rt operand (already forwarded).
- flush  in  1  abort in-flight op / squash current op.
- start  out  1  combinational; 1 when op is mult/multu/div/divu, busy==0 and flush==0.
- busy  out  1  registered; 1 while an operation is in flight.
- done  out  1  registered one-cycle pulse in the cycle after HI/LO commit.
- rdata  out  WIDTH  combinational; HI for MFHI, LO for MFLO, 0 otherwise.

Behaviour:
- Reset: HI=0, LO=0, busy=0, done=0, counter=0, temp result=0. An in-flight op is discarded.
- Issue (start==1 at edge T):
  - Compute the full result from a and b and latch it into temp registers.
  - Set busy=1 and counter to MUL_LAT or DIV_LAT.
- In flight:
  - busy stays high for exactly LAT cycles (T+1..T+LAT).
  - Counter decrements each cycle.
  - At the edge where counter==1: HI/LO take the temp value, busy becomes 0, done becomes 1 for one cycle.
  - mfhi/mflo issued in cycle T+LAT+1 returns the new value.
- Results:
  - mult: {HI,LO} = signed product, 2*WIDTH bits.
  - multu: {HI,LO} = unsigned product, 2*WIDTH bits.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundaries:
  - Divide by zero: busy and done behave normally; HI/LO are left unchanged at commit.
  - div of INT_MIN by -1: LO=INT_MIN, HI=0.
- mthi/mtlo:
  - Write HI or LO (from a) at the edge, only if busy==0 and flush==0.
  - While busy they are ignored; the stall unit guarantees they are not presented then.
- Ops while busy: any mult/div op presented is ignored and start=0; the stall unit stalls it.
- flush:
  - When flush==1 and busy==1: next edge busy=0, counter=0, done stays 0, HI/LO unchanged.
  - When flush==1 and busy==0: the op in E is squashed and start=0; mthi/mtlo are not written.
  - flush coincident with the commit edge (counter==1): the flush wins and HI/LO are not updated.
- Back-to-back: a new op may issue in the cycle immediately after busy falls.
- Latency-1 case: busy is high for 1 cycle and HI/LO commit at edge T+1.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds ops MADD, MADDU, MSUB, MSUBU with MUL_LAT latency.
  - At commit, {HI,LO} = {HI,LO} ± product.
  - The accumulation uses the HI/LO values at commit time; no intervening writes are possible because the unit is busy.
- Not defined:
  - These opcodes are decoded as MDU_NONE: start=0 and no state change.

Decomposition:
- Package mdu_pkg holds:
  - op enum: MDU_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
  - Helpers for the is_muldiv and is_mul op classes.
  - The default latency constants.
- One sub-module, mdu_lat_counter:
  - Loads LAT on issue, decrements, clears on flush.
  - Produces busy and the commit strobe.
  - Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1).

Test Plan:
- mult, a=-3, b=7, MUL_LAT=5 → start=1 at T, busy=1 over T+1..T+5, done at T+6, mfhi=0xFFFFFFFF, mflo=0xFFFFFFEB.
- divu a=100, b=7 then div a=-7, b=2 (DIV_LAT=10) → LO=14, HI=2, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; busy 10 cycles each, back-to-back issue accepted.
- div a=5, b=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo → after 10 busy cycles HI=0x11, LO=0x22, done=1.
- multu issued, flush=1 at T+2 → busy=0 at T+3, done never asserted, HI/LO keep the pre-issue values; a new mult at T+3 issues normally.
- mthi a=0xABCD presented while busy → ignored; after commit, HI equals the product's high half, not 0xABCD.
- reset=0 mid-div → busy=0, done=0, HI=LO=0 next cycle. With MDU_MADD_EN: HI=0, LO=10, then madd a=2, b=3 → LO=16, HI=0.
